// File: rtl/msrv32_dmem_bus_ctrl.sv
// Data-memory bus controller for the MSRV32 pipeline.
// Accepts one load/store at a time from the pipeline, drives a single-beat
// request on the memory bus until hready, then returns a one-cycle response.
// Misaligned requests never reach the bus. A stuck bus ends in a bus-error
// pulse after TIMEOUT wait cycles.

module msrv32_dmem_bus_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_n_in,

    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic             mem_wr_req_in,
    input  logic [WIDTH-1:0] iadder_in,
    input  logic [1:0]       load_size_in,
    input  logic             load_unsigned_in,
    input  logic [WIDTH-1:0] rs2_in,
    input  logic             flush_in,

    output logic [WIDTH-1:0] ms_riscv32_mp_dmaddr_out,
    output logic             ms_riscv32_mp_dm_req_out,
    output logic             ms_riscv32_mp_dmwr_req_out,
    output logic [3:0]       ms_riscv32_mp_dmwr_mask_out,
    output logic [WIDTH-1:0] ms_riscv32_mp_dmdata_out,
    input  logic             ms_riscv32_mp_hready_in,
    input  logic [WIDTH-1:0] ms_riscv32_mp_dmdata_in,

    output logic             rsp_valid_out,
    output logic [WIDTH-1:0] dmdata_out,
    output logic [1:0]       iadder_out_1_to_0_out,
    output logic [1:0]       load_size_out,
    output logic             load_unsigned_out,

    output logic             stall_out,
    output logic             misaligned_out,
    output logic             bus_err_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [CNT_W-1:0] wait_cnt;
    logic             wr_q;
    logic [3:0]       mask_q;
    logic             flush_pending;

    logic             misaligned_req;
    logic [3:0]       req_mask;
    logic [WIDTH-1:0] req_wdata;
    logic             accept;
    logic             accept_ok;
    logic             timeout_hit;

    // Decode byte enables, replicated store data and alignment from the incoming request
    always_comb begin
        misaligned_req = 1'b0;
        req_mask       = 4'b0000;
        req_wdata      = rs2_in;
        case (load_size_in)
            2'b00: begin
                req_mask  = 4'b0001 << iadder_in[1:0];
                req_wdata = {4{rs2_in[7:0]}};
            end
            2'b01: begin
                misaligned_req = iadder_in[0];
                req_mask       = 4'b0011 << {iadder_in[1], 1'b0};
                req_wdata      = {2{rs2_in[15:0]}};
            end
            default: begin
                misaligned_req = |iadder_in[1:0];
                req_mask       = 4'b1111;
                req_wdata      = rs2_in;
            end
        endcase
        if (!mem_wr_req_in) begin
            req_mask = 4'b0000;
        end
    end

    assign accept      = (state == IDLE) && req_valid_in;
    assign accept_ok   = accept && !misaligned_req;
    assign timeout_hit = (state == REQ) && !ms_riscv32_mp_hready_in &&
                         (wait_cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept aligned ops, wait for hready or timeout, one response cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_ok) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (ms_riscv32_mp_hready_in) begin
                    next_state = RESP;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Wait counter: cleared when a request is launched, counts REQ cycles without hready
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            wait_cnt <= '0;
        end else if (accept_ok) begin
            wait_cnt <= '0;
        end else if ((state == REQ) && !ms_riscv32_mp_hready_in) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Capture the accepted request so bus and load-unit fields stay stable for its lifetime
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            ms_riscv32_mp_dmaddr_out <= '0;
            ms_riscv32_mp_dmdata_out <= '0;
            mask_q                   <= 4'b0000;
            wr_q                     <= 1'b0;
            iadder_out_1_to_0_out    <= 2'b00;
            load_size_out            <= 2'b00;
            load_unsigned_out        <= 1'b0;
        end else if (accept_ok) begin
            ms_riscv32_mp_dmaddr_out <= {iadder_in[WIDTH-1:2], 2'b00};
            ms_riscv32_mp_dmdata_out <= req_wdata;
            mask_q                   <= req_mask;
            wr_q                     <= mem_wr_req_in;
            iadder_out_1_to_0_out    <= iadder_in[1:0];
            load_size_out            <= load_size_in;
            load_unsigned_out        <= load_unsigned_in;
        end
    end

    // Latch the read word when a load completes; stores leave the last word in place
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            dmdata_out <= '0;
        end else if ((state == REQ) && ms_riscv32_mp_hready_in && !wr_q) begin
            dmdata_out <= ms_riscv32_mp_dmdata_in;
        end
    end

    // Remember a flush seen while the bus access is in flight so its response is dropped
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            flush_pending <= 1'b0;
        end else if (accept_ok) begin
            flush_pending <= 1'b0;
        end else if ((state == REQ) && flush_in) begin
            flush_pending <= 1'b1;
        end
    end

    // One-cycle exception pulses for misaligned requests and bus timeouts
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            misaligned_out <= 1'b0;
            bus_err_out    <= 1'b0;
        end else begin
            misaligned_out <= accept && misaligned_req;
            bus_err_out    <= timeout_hit;
        end
    end

    assign req_ready_out               = (state == IDLE);
    assign stall_out                   = (state != IDLE);
    assign ms_riscv32_mp_dm_req_out    = (state == REQ);
    assign ms_riscv32_mp_dmwr_req_out  = (state == REQ) && wr_q;
    assign ms_riscv32_mp_dmwr_mask_out = (state == REQ) ? mask_q : 4'b0000;
    assign rsp_valid_out               = (state == RESP) && !flush_pending && !flush_in;

endmodule

// File: tb/tb_msrv32_dmem_bus_ctrl.sv
// Directed self-checking bench for msrv32_dmem_bus_ctrl.
// Inputs change 1 ns after the rising edge; outputs are checked after settling.

module tb_msrv32_dmem_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_wr;
    logic [31:0] iadder;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [31:0] rs2;
    logic        flush;
    logic [31:0] dmaddr;
    logic        dm_req;
    logic        dmwr_req;
    logic [3:0]  dmwr_mask;
    logic [31:0] dmdata_bus;
    logic        hready;
    logic [31:0] dmdata_in;
    logic        rsp_valid;
    logic [31:0] dmdata_rd;
    logic [1:0]  iadder_lo;
    logic [1:0]  load_size_q;
    logic        load_unsigned_q;
    logic        stall;
    logic        misaligned;
    logic        bus_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    msrv32_dmem_bus_ctrl #(.WIDTH(32), .TIMEOUT(16)) dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_n_in      (rst_n),
        .req_valid_in                (req_valid),
        .req_ready_out               (req_ready),
        .mem_wr_req_in               (mem_wr),
        .iadder_in                   (iadder),
        .load_size_in                (load_size),
        .load_unsigned_in            (load_unsigned),
        .rs2_in                      (rs2),
        .flush_in                    (flush),
        .ms_riscv32_mp_dmaddr_out    (dmaddr),
        .ms_riscv32_mp_dm_req_out    (dm_req),
        .ms_riscv32_mp_dmwr_req_out  (dmwr_req),
        .ms_riscv32_mp_dmwr_mask_out (dmwr_mask),
        .ms_riscv32_mp_dmdata_out    (dmdata_bus),
        .ms_riscv32_mp_hready_in     (hready),
        .ms_riscv32_mp_dmdata_in     (dmdata_in),
        .rsp_valid_out               (rsp_valid),
        .dmdata_out                  (dmdata_rd),
        .iadder_out_1_to_0_out       (iadder_lo),
        .load_size_out               (load_size_q),
        .load_unsigned_out           (load_unsigned_q),
        .stall_out                   (stall),
        .misaligned_out              (misaligned),
        .bus_err_out                 (bus_err)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of pipeline and bus inputs
    task automatic applyStimulus(input logic valid, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic uns, input logic [31:0] data,
                                 input logic fl, input logic rdy, input logic [31:0] rdata);
        req_valid     = valid;
        mem_wr        = wr;
        iadder        = addr;
        load_size     = size;
        load_unsigned = uns;
        rs2           = data;
        flush         = fl;
        hready        = rdy;
        dmdata_in     = rdata;
    endtask

    // Advance one clock and let outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #12;
        checkOutput("rst_ready",   {31'b0, req_ready}, 32'd1);
        checkOutput("rst_stall",   {31'b0, stall},     32'd0);
        checkOutput("rst_dm_req",  {31'b0, dm_req},    32'd0);
        checkOutput("rst_rsp",     {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_mask",    {28'b0, dmwr_mask}, 32'd0);
        checkOutput("rst_dmaddr",  dmaddr,             32'd0);
        checkOutput("rst_dmdata",  dmdata_rd,          32'd0);
        checkOutput("rst_bus_err", {31'b0, bus_err},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] load word 0x00001004");
        applyStimulus(1'b1, 1'b0, 32'h0000_1004, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        checkOutput("lw_dm_req",   {31'b0, dm_req},    32'd1);
        checkOutput("lw_dmaddr",   dmaddr,             32'h0000_1004);
        checkOutput("lw_mask",     {28'b0, dmwr_mask}, 32'h0);
        checkOutput("lw_dmwr",     {31'b0, dmwr_req},  32'd0);
        checkOutput("lw_ready",    {31'b0, req_ready}, 32'd0);
        checkOutput("lw_rsp_early",{31'b0, rsp_valid}, 32'd0);
        checkOutput("lw_size_q",   {30'b0, load_size_q}, 32'd2);
        tick();
        checkOutput("lw_rsp",      {31'b0, rsp_valid}, 32'd1);
        checkOutput("lw_rdata",    dmdata_rd,          32'hDEAD_BEEF);
        checkOutput("lw_dm_req_off", {31'b0, dm_req},  32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("lw_rsp_once", {31'b0, rsp_valid}, 32'd0);
        checkOutput("lw_idle",     {31'b0, req_ready}, 32'd1);

        $display("[TB] store byte 0x00002003");
        applyStimulus(1'b1, 1'b1, 32'h0000_2003, 2'b00, 1'b0, 32'h0000_00A5, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
        #1;
        checkOutput("sb_mask",     {28'b0, dmwr_mask}, 32'h8);
        checkOutput("sb_wdata",    dmdata_bus,         32'hA5A5_A5A5);
        checkOutput("sb_dmwr",     {31'b0, dmwr_req},  32'd1);
        checkOutput("sb_dmaddr",   dmaddr,             32'h0000_2000);
        checkOutput("sb_lo",       {30'b0, iadder_lo}, 32'd3);
        tick();
        checkOutput("sb_rsp",      {31'b0, rsp_valid}, 32'd1);
        checkOutput("sb_rdata_kept", dmdata_rd,        32'hDEAD_BEEF);
        checkOutput("sb_mask_off", {28'b0, dmwr_mask}, 32'h0);
        checkOutput("sb_dmwr_off", {31'b0, dmwr_req},  32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("[TB] misaligned load half 0x00003001");
        applyStimulus(1'b1, 1'b0, 32'h0000_3001, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("mis_pulse",   {31'b0, misaligned}, 32'd1);
        checkOutput("mis_dm_req",  {31'b0, dm_req},     32'd0);
        checkOutput("mis_ready",   {31'b0, req_ready},  32'd1);
        checkOutput("mis_stall",   {31'b0, stall},      32'd0);
        checkOutput("mis_addr_hold", dmaddr,            32'h0000_2000);
        tick();
        checkOutput("mis_pulse_end", {31'b0, misaligned}, 32'd0);
        checkOutput("mis_dm_req2", {31'b0, dm_req},     32'd0);

        $display("[TB] load size 11 with 3 wait cycles, extra valid ignored");
        applyStimulus(1'b1, 1'b0, 32'h0000_4008, 2'b11, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'hFFFF_0000, 2'b10, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 32'h0);
            #1;
            checkOutput("wt_dm_req",  {31'b0, dm_req},    32'd1);
            checkOutput("wt_dmaddr",  dmaddr,             32'h0000_4008);
            checkOutput("wt_dmwr",    {31'b0, dmwr_req},  32'd0);
            checkOutput("wt_stall",   {31'b0, stall},     32'd1);
            checkOutput("wt_rsp",     {31'b0, rsp_valid}, 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        #1;
        checkOutput("wt_dmaddr4",  dmaddr,             32'h0000_4008);
        checkOutput("wt_uns_q",    {31'b0, load_unsigned_q}, 32'd1);
        checkOutput("wt_size_q",   {30'b0, load_size_q}, 32'd3);
        tick();
        checkOutput("wt_rsp_done", {31'b0, rsp_valid}, 32'd1);
        checkOutput("wt_rdata",    dmdata_rd,          32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("[TB] store word with hready stuck low");
        applyStimulus(1'b1, 1'b1, 32'h0000_5000, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("to_mask",     {28'b0, dmwr_mask}, 32'hF);
        checkOutput("to_wdata",    dmdata_bus,         32'hCAFE_F00D);
        for (int i = 0; i < 16; i++) begin
            checkOutput("to_dm_req",  {31'b0, dm_req},  32'd1);
            checkOutput("to_no_err",  {31'b0, bus_err}, 32'd0);
            tick();
        end
        checkOutput("to_bus_err",  {31'b0, bus_err},   32'd1);
        checkOutput("to_dm_off",   {31'b0, dm_req},    32'd0);
        checkOutput("to_ready",    {31'b0, req_ready}, 32'd1);
        checkOutput("to_no_rsp",   {31'b0, rsp_valid}, 32'd0);
        tick();
        checkOutput("to_err_end",  {31'b0, bus_err},   32'd0);
        checkOutput("to_no_rsp2",  {31'b0, rsp_valid}, 32'd0);

        $display("[TB] store half 0x00006002");
        applyStimulus(1'b1, 1'b1, 32'h0000_6002, 2'b01, 1'b0, 32'h1234_BEEF, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        #1;
        checkOutput("sh_mask",     {28'b0, dmwr_mask}, 32'hC);
        checkOutput("sh_wdata",    dmdata_bus,         32'hBEEF_BEEF);
        tick();
        checkOutput("sh_rsp",      {31'b0, rsp_valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("[TB] flush during REQ");
        applyStimulus(1'b1, 1'b0, 32'h0000_7000, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55AA_55AA);
        #1;
        checkOutput("fl_dm_req",   {31'b0, dm_req},    32'd1);
        tick();
        checkOutput("fl_no_rsp",   {31'b0, rsp_valid}, 32'd0);
        checkOutput("fl_rdata",    dmdata_rd,          32'h55AA_55AA);
        checkOutput("fl_stall",    {31'b0, stall},     32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("fl_idle",     {31'b0, req_ready}, 32'd1);

        $display("[TB] flush during RESP");
        applyStimulus(1'b1, 1'b0, 32'h0000_7004, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("flr_no_rsp",  {31'b0, rsp_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("[TB] reset asserted mid-REQ");
        applyStimulus(1'b1, 1'b0, 32'h0000_8000, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("rm_dm_req_on", {31'b0, dm_req},   32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rm_dm_req",   {31'b0, dm_req},    32'd0);
        checkOutput("rm_ready",    {31'b0, req_ready}, 32'd1);
        checkOutput("rm_rsp",      {31'b0, rsp_valid}, 32'd0);
        checkOutput("rm_dmaddr",   dmaddr,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0000_A000, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_0001);
        #1;
        checkOutput("rm_reaccept", {31'b0, dm_req},    32'd1);
        checkOutput("rm_addr",     dmaddr,             32'h0000_A000);
        tick();
        checkOutput("rm_rsp_after", {31'b0, rsp_valid}, 32'd1);
        checkOutput("rm_rdata",    dmdata_rd,          32'h7777_0001);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/msrv32_dmem_bus_ctrl.md
MSRV32_DMEM_BUS_CTRL -- requirements
Module: msrv32_dmem_bus_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, datapath width; TIMEOUT, 16, maximum wait cycles for hready before bus error.
REQ-002 Port: ms_riscv32_mp_clk_in  input  1  single clock, rising edge.
REQ-003 Port: ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid_in  input  1  pipeline has a memory op; req_ready_out  output  1  block accepts the op this cycle.
REQ-005 Port: mem_wr_req_in  input  1  1=store, 0=load; iadder_in  input  WIDTH  byte address; load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word; load_unsigned_in  input  1  pass-through; rs2_in  input  WIDTH  store data; flush_in  input  1  discard pending response.
REQ-006 Port: ms_riscv32_mp_dmaddr_out  output  WIDTH  word address {iadder[31:2],2'b00}; ms_riscv32_mp_dm_req_out  output  1  bus request; ms_riscv32_mp_dmwr_req_out  output  1  write; ms_riscv32_mp_dmwr_mask_out  output  4  byte enables; ms_riscv32_mp_dmdata_out  output  WIDTH  write data.
REQ-007 Port: ms_riscv32_mp_hready_in  input  1  memory completes this cycle; ms_riscv32_mp_dmdata_in  input  WIDTH  read data valid when hready high.
REQ-008 Port: rsp_valid_out  output  1  one-cycle completion pulse; dmdata_out  output  WIDTH  captured read word; iadder_out_1_to_0_out  output  2, load_size_out  output  2, load_unsigned_out  output  1  registered request fields for the load unit.
REQ-009 Port: stall_out  output  1  pipeline hold; misaligned_out  output  1  one-cycle misaligned pulse; bus_err_out  output  1  one-cycle timeout pulse.

Function
REQ-010 FSM SHALL have states IDLE, REQ, RESP; req_ready_out = (state==IDLE); stall_out = (state!=IDLE).
REQ-011 IDLE with req_valid_in=1 and aligned address SHALL register address, size, unsigned, wr flag, mask, store data and go to REQ next cycle.
REQ-012 Misaligned: half with iadder[0]=1, word/11 with iadder[1:0]!=0; SHALL pulse misaligned_out the cycle after acceptance, issue no bus access, remain IDLE.
REQ-013 In REQ, dm_req_out=1 and all bus outputs SHALL be held stable until hready sampled high.
REQ-014 hready high in REQ SHALL capture dmdata_in into dmdata_out (loads only; stores leave it unchanged) and go to RESP.
REQ-015 RESP SHALL assert rsp_valid_out for exactly one cycle, then go to IDLE; minimum accept-to-rsp_valid latency is 2 cycles (hready in first REQ cycle).
REQ-016 Write mask: byte 4'b0001<<iadder[1:0]; half 4'b0011<<{iadder[1],1'b0}; word 4'b1111; loads SHALL drive mask 4'b0000 and dmwr_req_out=0.
REQ-017 Store data: byte {4{rs2[7:0]}}; half {2{rs2[15:0]}}; word rs2_in.
REQ-018 Wait counter SHALL clear on entry to REQ, increment each REQ cycle with hready low; reaching TIMEOUT SHALL pulse bus_err_out, drop dm_req_out, return to IDLE, no rsp_valid_out.
REQ-019 flush_in in REQ SHALL NOT abort the bus transaction but SHALL suppress the subsequent rsp_valid_out; flush_in in IDLE/RESP SHALL suppress that cycle's or no pulse respectively (RESP pulse suppressed).
REQ-020 req_valid_in in REQ/RESP SHALL be ignored (ready low); no request queueing.
REQ-021 Outside REQ: dm_req_out=0, dmwr_req_out=0, mask=0; dmaddr_out/dmdata_out hold last values.

Reset
REQ-022 Reset assertion SHALL asynchronously force state IDLE, counter 0, and all outputs 0 except req_ready_out=1.
REQ-023 Reset mid-REQ SHALL drop dm_req_out immediately without a response; first accept allowed on first clock edge after deassertion.

Verification
REQ-024 Load word 0x0000_1004, hready high first REQ cycle, dmdata_in 0xDEAD_BEEF -> dmaddr 0x0000_1004, mask 0000, rsp_valid 2 cycles after accept, dmdata_out 0xDEAD_BEEF.
REQ-025 Store byte addr 0x0000_2003, rs2 0x0000_00A5 -> mask 1000, dmdata_out bus 0xA5A5_A5A5, dmwr_req 1, rsp_valid pulse.
REQ-026 Load half addr 0x0000_3001 -> misaligned_out pulse, dm_req_out never asserted, ready stays 1.
REQ-027 Load word, hready low 3 cycles -> bus outputs stable 4 REQ cycles, stall_out 1 throughout, rsp_valid after hready.
REQ-028 hready held low -> bus_err_out pulse after 16 REQ cycles, state IDLE, no rsp_valid.
REQ-029 flush_in during REQ then hready -> no rsp_valid; reset asserted mid-REQ -> dm_req_out 0 immediately, ready 1.
